// File: rtl/framebuffer_nseg.sv
// Double-buffered RGB framebuffer read as N_SEG parallel row segments, one bit plane at a time.
// Optional macro FRAMEBUFFER_NSEG_WSTRB_EN enables per-byte write enables; otherwise every write stores the full pixel.
module framebuffer_nseg #(
    parameter int N_ROWS_MAX     = 64,
    parameter int N_COLS_MAX     = 256,
    parameter int BITDEPTH_MAX   = 8,
    parameter int N_SEG          = 2,
    parameter int CTRL_REG_WIDTH = 32
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    w_en,
    input  logic [$clog2(N_ROWS_MAX*N_COLS_MAX)-1:0]                w_addr,
    input  logic [3:0]                                              w_strb,
    input  logic [31:0]                                             w_din,
    input  logic [CTRL_REG_WIDTH-1:0]                               ctrl_bitdepth,
    input  logic                                                    swap_req,
    input  logic                                                    r_frame_done,
    output logic                                                    swap_ack,
    output logic                                                    front_buf,
    input  logic                                                    r_en,
    input  logic [$clog2(N_ROWS_MAX*N_COLS_MAX)-$clog2(N_SEG)-1:0]  r_addr,
    input  logic [$clog2(BITDEPTH_MAX)-1:0]                         r_bit,
    output logic [3*N_SEG-1:0]                                      r_dout,
    output logic                                                    r_valid
);

    localparam int DEPTH   = N_ROWS_MAX * N_COLS_MAX;
    localparam int AW      = $clog2(DEPTH);
    localparam int DEW     = $clog2(BITDEPTH_MAX + 1);
    localparam int SEG_PIX = DEPTH / N_SEG;

    localparam logic IDLE    = 1'b0;
    localparam logic PENDING = 1'b1;

    // Buffer 0 occupies the lower DEPTH entries, buffer 1 the upper DEPTH entries.
    logic [23:0] mem [0:2*DEPTH-1];

    logic            state;
    logic            do_swap;
    logic [AW:0]     wr_idx;
    logic [AW:0]     rd_base;
    logic [2:0]      byte_en;
    logic [DEW-1:0]  d_eff;
    logic [DEW-1:0]  bit_idx;
    logic            plane_on;
    logic [4:0]      idx_r;
    logic [4:0]      idx_g;
    logic [4:0]      idx_b;
    logic [3*N_SEG-1:0] rgb_next;
    logic            unused_inputs;

    assign unused_inputs = ^{w_din[31:24], w_strb};

`ifdef FRAMEBUFFER_NSEG_WSTRB_EN
    assign byte_en = w_strb[2:0];
`else
    assign byte_en = 3'b111;
`endif

    assign wr_idx  = front_buf ? {1'b0, w_addr} : ({1'b0, w_addr} + (AW+1)'(DEPTH));
    assign rd_base = front_buf ? (AW+1)'(DEPTH) : '0;

    always_ff @(posedge clk) begin
        if (w_en) begin
            if (byte_en[0]) mem[wr_idx][7:0]   <= w_din[7:0];
            if (byte_en[1]) mem[wr_idx][15:8]  <= w_din[15:8];
            if (byte_en[2]) mem[wr_idx][23:16] <= w_din[23:16];
        end
    end

    // Out-of-range depths (including zero) fall back to the full depth; planes are taken from the MSB end.
    always_comb begin
        if (ctrl_bitdepth == '0 || ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX)) begin
            d_eff = DEW'(BITDEPTH_MAX);
        end else begin
            d_eff = ctrl_bitdepth[DEW-1:0];
        end
        plane_on = DEW'(r_bit) < d_eff;
        bit_idx  = DEW'(BITDEPTH_MAX) - d_eff + DEW'(r_bit);
        idx_b    = 5'(bit_idx);
        idx_g    = 5'd8 + 5'(bit_idx);
        idx_r    = 5'd16 + 5'(bit_idx);
    end

    always_comb begin
        logic [AW:0]  idx;
        logic [23:0]  pix;
        rgb_next = '0;
        idx      = '0;
        pix      = '0;
        for (int s = 0; s < N_SEG; s++) begin
            idx = rd_base + (AW+1)'(s * SEG_PIX) + (AW+1)'(r_addr);
            pix = mem[idx];
            if (plane_on) begin
                rgb_next[3*(N_SEG-1-s) +: 3] = {pix[idx_r], pix[idx_g], pix[idx_b]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= r_en;
            if (r_en) begin
                r_dout <= rgb_next;
            end
        end
    end

    // A frame-done edge completes either a queued request or one arriving on the same edge.
    assign do_swap = r_frame_done && (state == PENDING || swap_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            front_buf <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= do_swap;
            if (do_swap) begin
                front_buf <= ~front_buf;
                state     <= IDLE;
            end else if (state == IDLE && swap_req) begin
                state <= PENDING;
            end
        end
    end

endmodule
